// File: rtl/arbitro_memoria_if.sv
// Requester and memory-side signals of arbitro_memoria.
// slave = arbiter view, master = requesters plus memory view.
interface arbitro_memoria_if;
  logic        data_req;
  logic        data_we;
  logic [5:0]  data_addr;
  logic [15:0] data_wdata;
  logic        data_ack;
  logic        fetch_req;
  logic [5:0]  fetch_addr;
  logic        fetch_ack;
  logic        disp_req;
  logic [5:0]  disp_addr;
  logic        disp_ack;
  logic [15:0] rdata;
  logic        err;
  logic [5:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_rdata;

  modport slave (
    input  data_req, data_we, data_addr, data_wdata, fetch_req, fetch_addr,
           disp_req, disp_addr, mem_rdata,
    output data_ack, fetch_ack, disp_ack, rdata, err,
           mem_addr, mem_wdata, mem_read, mem_write
  );

  modport master (
    output data_req, data_we, data_addr, data_wdata, fetch_req, fetch_addr,
           disp_req, disp_addr, mem_rdata,
    input  data_ack, fetch_ack, disp_ack, rdata, err,
           mem_addr, mem_wdata, mem_read, mem_write
  );
endinterface

// File: rtl/arbitro_memoria.sv
// Three-requester memory arbiter (data > fetch > display), 3-cycle accesses.
// ARB_DISPLAY_PORT_EN enables the display port and its starvation counter.
module arbitro_memoria #(
  parameter int unsigned MEM_WORDS  = 50,
  parameter int unsigned STARVE_MAX = 7
) (
  input logic               clock,
  input logic               reset_n,
  arbitro_memoria_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, COMPLETE} state_t;
  typedef enum logic [1:0] {G_DATA, G_FETCH, G_DISP} grant_t;

  state_t      r_state;
  grant_t      r_gnt;
  logic        r_we;
  logic        r_oor;
  logic [2:0]  r_ack;
  logic        r_err;
  logic        r_mem_read;
  logic        r_mem_write;
  logic [5:0]  r_mem_addr;
  logic [15:0] r_mem_wdata;
  logic [15:0] r_rdata;

  logic        w_disp_req;
  logic [5:0]  w_disp_addr;
  logic        w_starve_hit;
  logic        w_any;
  grant_t      w_gnt;
  logic [5:0]  w_addr;
  logic        w_legal;
  logic        w_we;

`ifdef ARB_DISPLAY_PORT_EN
  logic [2:0]  r_starve;

  assign w_disp_req   = bus.disp_req;
  assign w_disp_addr  = bus.disp_addr;
  assign w_starve_hit = (r_starve == 3'(STARVE_MAX));
  assign bus.disp_ack = r_ack[2];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_starve <= '0;
    end else if (!bus.disp_req) begin
      r_starve <= '0;
    end else if (r_state == IDLE && w_any) begin
      r_starve <= (w_gnt == G_DISP) ? '0 : r_starve + 3'd1;
    end
  end
`else
  logic w_unused;

  assign w_disp_req   = 1'b0;
  assign w_disp_addr  = '0;
  assign w_starve_hit = 1'b0;
  assign bus.disp_ack = 1'b0;
  assign w_unused     = ^{bus.disp_req, bus.disp_addr, r_ack[2], 3'(STARVE_MAX)};
`endif

  always_comb begin
    w_any = 1'b1;
    w_gnt = G_DATA;
    if (w_disp_req && w_starve_hit) begin
      w_gnt = G_DISP;
    end else if (bus.data_req) begin
      w_gnt = G_DATA;
    end else if (bus.fetch_req) begin
      w_gnt = G_FETCH;
    end else if (w_disp_req) begin
      w_gnt = G_DISP;
    end else begin
      w_any = 1'b0;
    end
  end

  always_comb begin
    w_addr = bus.data_addr;
    if (w_gnt == G_FETCH) begin
      w_addr = bus.fetch_addr;
    end else if (w_gnt == G_DISP) begin
      w_addr = w_disp_addr;
    end
  end

  assign w_legal = (32'(w_addr) < MEM_WORDS);
  assign w_we    = (w_gnt == G_DATA) && bus.data_we;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_gnt       <= G_DATA;
      r_we        <= 1'b0;
      r_oor       <= 1'b0;
      r_ack       <= '0;
      r_err       <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rdata     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_state     <= ACCESS;
            r_gnt       <= w_gnt;
            r_we        <= w_we;
            r_oor       <= !w_legal;
            r_mem_addr  <= w_addr;
            r_mem_read  <= w_legal && !w_we;
            r_mem_write <= w_legal && w_we;
            if (w_gnt == G_DATA) begin
              r_mem_wdata <= bus.data_wdata;
            end
          end
        end
        ACCESS: begin
          r_state     <= COMPLETE;
          r_mem_read  <= 1'b0;
          r_mem_write <= 1'b0;
          r_err       <= r_oor;
          case (r_gnt)
            G_FETCH: r_ack <= 3'b010;
            G_DISP:  r_ack <= 3'b100;
            default: r_ack <= 3'b001;
          endcase
        end
        default: begin
          r_state <= IDLE;
          r_ack   <= '0;
          r_err   <= 1'b0;
          if (!r_we) begin
            r_rdata <= r_oor ? '0 : bus.mem_rdata;
          end
        end
      endcase
    end
  end

  assign bus.data_ack  = r_ack[0];
  assign bus.fetch_ack = r_ack[1];
  assign bus.err       = r_err;
  assign bus.mem_read  = r_mem_read;
  assign bus.mem_write = r_mem_write;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  // Memory answers only during COMPLETE, so the ack cycle forwards it; the register holds it afterwards.
  assign bus.rdata = (r_state == COMPLETE && !r_we) ? (r_oor ? '0 : bus.mem_rdata) : r_rdata;

endmodule

// File: tb/tb_arbitro_memoria.sv
// Randomized self-checking bench for arbitro_memoria against a transaction-level model.
module tb_arbitro_memoria;
  localparam int MEM_WORDS  = 50;
  localparam int STARVE_MAX = 7;
`ifdef ARB_DISPLAY_PORT_EN
  localparam bit DISP_EN = 1'b1;
`else
  localparam bit DISP_EN = 1'b0;
`endif

  logic clock;
  logic reset_n;
  arbitro_memoria_if bus();

  arbitro_memoria #(.MEM_WORDS(MEM_WORDS), .STARVE_MAX(STARVE_MAX)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [15:0] mem [0:63];
  logic [15:0] ref_mem [0:63];
  logic [15:0] m_last;
  int          m_starve;
  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_rd = 0, n_wr = 0, n_multi = 0, n_disp_seen = 0;

  always @(posedge clock) if (bus.mem_read) bus.mem_rdata <= mem[bus.mem_addr];
  always @(negedge clock) if (bus.mem_write) mem[bus.mem_addr] <= bus.mem_wdata;

  always @(negedge clock) begin
    if (bus.mem_read) n_rd++;
    if (bus.mem_write) n_wr++;
    if (int'(bus.data_ack) + int'(bus.fetch_ack) + int'(bus.disp_ack) > 1) n_multi++;
    if (bus.disp_ack) n_disp_seen++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int pick(input int d_left, input bit f, input bit p, input int starve);
    if (DISP_EN && p && starve == STARVE_MAX) return 2;
    if (d_left > 0) return 0;
    if (f) return 1;
    if (DISP_EN && p) return 2;
    return -1;
  endfunction

  task automatic run_group(input bit want_d, input bit want_f, input bit want_p, input int d_reps,
                           input bit d_we, input logic [5:0] d_addr, input logic [15:0] d_wdata,
                           input logic [5:0] f_addr, input logic [5:0] p_addr);
    int d_left, n_acks, who, cyc, rd0, wr0, dsp0, n_disp_exp;
    bit f_pend, p_pend, is_wr, legal;
    logic [5:0]  a;
    logic [15:0] exp_rd;
    logic [2:0]  ackv;
    d_left     = want_d ? d_reps : 0;
    f_pend     = want_f;
    p_pend     = want_p;
    n_disp_exp = (DISP_EN && p_pend) ? 1 : 0;
    n_acks     = d_left + int'(f_pend) + n_disp_exp;
    dsp0       = n_disp_seen;
    @(negedge clock);
    bus.data_req = want_d;  bus.data_we = d_we;  bus.data_addr = d_addr;  bus.data_wdata = d_wdata;
    bus.fetch_req = want_f; bus.fetch_addr = f_addr;
    bus.disp_req = want_p;  bus.disp_addr = p_addr;
    rd0 = n_rd;
    wr0 = n_wr;
    for (int k = 0; k < n_acks; k++) begin
      cyc  = 0;
      ackv = '0;
      while (ackv == 3'b000 && cyc < 8) begin
        @(posedge clock); #1;
        cyc++;
        ackv = {bus.disp_ack, bus.fetch_ack, bus.data_ack};
      end
      if (ackv == 3'b000) begin
        check("ack_seen", 0, 1);
        break;
      end
      check("ack_latency", cyc, (k == 0) ? 2 : 3);
      who = pick(d_left, f_pend, p_pend, m_starve);
      check("grantee", ackv, 3'b001 << who);
      a      = (who == 0) ? d_addr : (who == 1) ? f_addr : p_addr;
      is_wr  = (who == 0) && d_we;
      legal  = int'(a) < MEM_WORDS;
      exp_rd = is_wr ? m_last : (legal ? ref_mem[a] : 16'h0000);
      check("err", bus.err, !legal);
      check("rdata", bus.rdata, exp_rd);
      check("mem_addr", bus.mem_addr, a);
      if (is_wr) check("mem_wdata", bus.mem_wdata, d_wdata);
      check("rd_strobes", n_rd - rd0, (legal && !is_wr) ? 1 : 0);
      check("wr_strobes", n_wr - wr0, (legal && is_wr) ? 1 : 0);
      rd0 = n_rd;
      wr0 = n_wr;
      if (!is_wr) m_last = exp_rd;
      else if (legal) ref_mem[a] = d_wdata;
      if (who == 2) m_starve = 0;
      else if (p_pend) m_starve++;
      if (who == 0) begin
        d_left--;
        if (d_left == 0) bus.data_req = 1'b0;
      end else if (who == 1) begin
        f_pend = 1'b0;
        bus.fetch_req = 1'b0;
      end else begin
        p_pend = 1'b0;
        bus.disp_req = 1'b0;
      end
    end
    @(posedge clock); #1;
    check("rdata_hold", bus.rdata, m_last);
    @(negedge clock);
    bus.data_req = 1'b0;
    bus.fetch_req = 1'b0;
    bus.disp_req = 1'b0;
    repeat (3) @(negedge clock);
    check("disp_acks", n_disp_seen - dsp0, n_disp_exp);
    m_starve = 0;
  endtask

  initial begin
    logic [15:0] v;
    reset_n = 1'b0;
    bus.data_req = 1'b0; bus.data_we = 1'b0; bus.data_addr = '0; bus.data_wdata = '0;
    bus.fetch_req = 1'b0; bus.fetch_addr = '0;
    bus.disp_req = 1'b0; bus.disp_addr = '0;
    bus.mem_rdata = '0;
    for (int i = 0; i < 64; i++) begin
      v = (i == 5) ? 16'h2161 : 16'($urandom);
      ref_mem[i] = v;
      mem[i] <= v;
    end
    m_last = '0;
    m_starve = 0;
    #2;
    check("rst_acks", {bus.disp_ack, bus.fetch_ack, bus.data_ack}, 0);
    check("rst_err", bus.err, 0);
    check("rst_strobes", {bus.mem_read, bus.mem_write}, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_rdata", bus.rdata, 0);
    @(negedge clock);
    reset_n = 1'b1;

    run_group(0, 1, 0, 0, 0, 6'd0, 16'h0, 6'd5, 6'd0);
    run_group(1, 0, 0, 1, 1, 6'd10, 16'hBEEF, 6'd0, 6'd0);
    run_group(1, 1, 0, 1, 0, 6'd12, 16'h0, 6'd20, 6'd0);
    run_group(1, 0, 1, 8, 0, 6'd3, 16'h0, 6'd0, 6'd30);
    run_group(0, 1, 0, 0, 0, 6'd0, 16'h0, 6'd50, 6'd0);
    run_group(1, 0, 0, 1, 1, 6'd63, 16'h1234, 6'd0, 6'd0);

    @(negedge clock);
    bus.fetch_req = 1'b1;
    bus.fetch_addr = 6'd7;
    @(posedge clock); #1;
    check("rst_pre_read", bus.mem_read, 1);
    reset_n = 1'b0;
    #1;
    check("rst_mid_read", bus.mem_read, 0);
    check("rst_mid_addr", bus.mem_addr, 0);
    check("rst_mid_rdata", bus.rdata, 0);
    bus.fetch_req = 1'b0;
    @(posedge clock); #1;
    check("rst_mid_acks", {bus.disp_ack, bus.fetch_ack, bus.data_ack, bus.err}, 0);
    @(negedge clock);
    reset_n = 1'b1;
    m_last = '0;
    m_starve = 0;
    run_group(0, 1, 0, 0, 0, 6'd0, 16'h0, 6'd7, 6'd0);

    for (int it = 0; it < 40; it++) begin
      bit wd, wf, wp;
      int reps;
      wd = 1'($urandom);
      wf = 1'($urandom);
      wp = 1'($urandom);
      if (!wd && !wf) wf = 1'b1;
      reps = ($urandom_range(0, 4) == 0) ? 8 : $urandom_range(1, 3);
      run_group(wd, wf, wp, reps, 1'($urandom),
                6'(($urandom_range(0, 4) == 0) ? $urandom_range(50, 63) : $urandom_range(0, 49)),
                16'($urandom),
                6'(($urandom_range(0, 4) == 0) ? $urandom_range(50, 63) : $urandom_range(0, 49)),
                6'(($urandom_range(0, 4) == 0) ? $urandom_range(50, 63) : $urandom_range(0, 49)));
    end

    begin
      int bad;
      bad = 0;
      for (int i = 0; i < 64; i++) if (mem[i] !== ref_mem[i]) bad++;
      check("mem_image", bad, 0);
    end
    check("multi_ack_cycles", n_multi, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule

// File: doc/arbitro_memoria.md
ARBITRO_MEMORIA -- requirements
Module: arbitro_memoria

Interface
REQ-001 The block SHALL have parameter MEM_WORDS, default 50, meaning number of valid memory words (legal addresses 0..MEM_WORDS-1).
REQ-002 The block SHALL have parameter STARVE_MAX, default 7, meaning consecutive non-display grants tolerated while display is pending.
REQ-003 The block SHALL have port clock  in  1  rising-edge clock; all state is clocked on it.
REQ-004 The block SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-005 The block SHALL have ports data_req in 1, data_we in 1, data_addr in 6, data_wdata in 16, data_ack out 1 (datapath load/store requester).
REQ-006 The block SHALL have ports fetch_req in 1, fetch_addr in 6, fetch_ack out 1 (instruction fetch requester, read-only).
REQ-007 The block SHALL have ports disp_req in 1, disp_addr in 6, disp_ack out 1 (display/key readout requester, read-only).
REQ-008 The block SHALL have ports rdata out 16 (read result), err out 1 (out-of-range flag, valid with any ack).
REQ-009 The block SHALL have memory-side ports mem_addr out 6, mem_wdata out 16, mem_read out 1 (memory samples on its rising edge), mem_write out 1 (memory commits on its falling edge), mem_rdata in 16.

Function
REQ-010 The FSM SHALL have states IDLE, ACCESS, COMPLETE; IDLE->ACCESS when any enabled req is high, ACCESS->COMPLETE always, COMPLETE->IDLE always.
REQ-011 In IDLE the block SHALL grant with fixed priority data > fetch > display, except REQ-014.
REQ-012 On grant the block SHALL register mem_addr, mem_wdata, direction and grantee; these SHALL stay stable through ACCESS and COMPLETE.
REQ-013 Read: mem_read=1 for exactly the ACCESS cycle; in COMPLETE mem_read=0 and rdata SHALL be loaded from mem_rdata at the COMPLETE->IDLE edge... rdata SHALL be valid during the ack cycle and held until the next completed read.
REQ-014 A 3-bit starvation counter SHALL increment on each data/fetch grant while disp_req is high, clear on display grant or disp_req low; when it equals STARVE_MAX and disp_req is high, display SHALL win the next grant.
REQ-015 Write (data_we=1 on data grant): mem_write=1 for exactly the ACCESS cycle, 0 in COMPLETE (falling edge commits); rdata unchanged.
REQ-016 The grantee's ack SHALL be high for exactly the COMPLETE cycle; at most one ack high per cycle; latency request-sampled-edge to ack = 2 cycles, 3 cycles per access.
REQ-017 Requesters SHALL hold req and operands until ack and deassert req by the cycle after ack; req sampled only in IDLE, so a held req after ack yields a second access.
REQ-018 Address >= MEM_WORDS: no mem_read/mem_write strobe, FSM still passes ACCESS, ack asserted with err=1, rdata=0 for reads; err=0 for legal accesses.
REQ-019 Simultaneous requests SHALL be resolved in the same IDLE cycle; losers wait without ack.

Reset
REQ-020 reset_n low SHALL immediately force: state IDLE, all acks 0, err 0, mem_read 0, mem_write 0, mem_addr 0, mem_wdata 0, rdata 0, starvation counter 0.
REQ-021 Reset during ACCESS SHALL abandon the transfer with no ack; a write in flight may commit (mem_write falling edge) and integrators SHALL qualify the memory write accordingly.

Configuration
REQ-022 Macro ARB_DISPLAY_PORT_EN defined: display port and starvation counter SHALL be implemented per REQ-011..014.
REQ-023 Macro undefined: disp_req ignored, disp_ack tied 0, no starvation counter; ports SHALL remain present; priority data > fetch only.

Verification
REQ-024 Fetch read addr 5 with mem_rdata=16'h2161 -> mem_read pulse 1 cycle, fetch_ack 2 cycles after sampling, rdata=16'h2161, err=0.
REQ-025 Data write addr 10 data 16'hBEEF -> mem_write high 1 cycle then low, mem_addr=10, mem_wdata=16'hBEEF, data_ack, rdata unchanged.
REQ-026 data_req and fetch_req asserted same cycle -> data_ack first, fetch_ack 3 cycles later, never both high.
REQ-027 disp_req held with data_req held continuously -> display granted on 8th grant (after 7 data grants); macro undefined -> disp_ack never asserts.
REQ-028 Fetch addr 50 -> no mem_read pulse, fetch_ack with err=1, rdata=0.
REQ-029 reset_n low during read ACCESS -> mem_read 0 immediately, no ack, outputs per REQ-020; after release next request served normally.
